// File: rtl/icache_ctrl_if.sv
// Core fetch and refill-bus handshake bundle for the instruction-cache controller.
// The master modport is the controller's view; slave is the core/bus side.
`timescale 1ns/1ps
interface icache_ctrl_if;
   logic        core_req_valid;
   logic        core_req_ready;
   logic [31:0] core_req_addr;
   logic        core_rsp_valid;
   logic [31:0] core_rsp_data;
   logic        flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;

   modport master (
      input  core_req_valid, core_req_addr, flush,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output core_req_ready, core_rsp_valid, core_rsp_data,
      output mem_req_valid, mem_req_addr
   );

   modport slave (
      output core_req_valid, core_req_addr, flush,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  core_req_ready, core_rsp_valid, core_rsp_data,
      input  mem_req_valid, mem_req_addr
   );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction-cache controller: fetches read SRAM port 1, line
// refills write SRAM port 0; tags and valid bits live in flops here.
`timescale 1ns/1ps
module icache_ctrl #(
   parameter int ADDR_WIDTH = 11,
   parameter int LINE_WORDS = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   icache_ctrl_if.master         bus,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [3:0]            sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   localparam int OFF   = $clog2(LINE_WORDS);
   localparam int IDX_W = ADDR_WIDTH - OFF;
   localparam int TAG_W = 30 - ADDR_WIDTH;
   localparam int LINES = 1 << IDX_W;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REFILL_REQ,
      REFILL,
      RESPOND
   } state_t;

   state_t state, state_next;

   logic [TAG_W-1:0]      req_tag;
   logic [IDX_W-1:0]      req_idx;
   logic [OFF-1:0]        req_off;
   logic [OFF-1:0]        beat_cnt;
   logic [DATA_WIDTH-1:0] crit_word;
   logic                  flush_pending;
   logic [LINES-1:0]      valid_bits;
   logic [TAG_W-1:0]      tag_ram [LINES];

   logic [TAG_W-1:0] in_tag;
   logic [IDX_W-1:0] in_idx;
   logic [OFF-1:0]   in_off;
   logic             accept;
   logic             hit;
   logic             beat;
   logic             last_beat;
   logic             unused_addr_bits;

   assign in_tag = bus.core_req_addr[31:ADDR_WIDTH+2];
   assign in_idx = bus.core_req_addr[ADDR_WIDTH+1:OFF+2];
   assign in_off = bus.core_req_addr[OFF+1:2];
   assign unused_addr_bits = ^bus.core_req_addr[1:0];

   // A flush, requested now or left pending from a refill, takes the IDLE
   // cycle for itself so no lookup can race the valid-bit clear.
   assign bus.core_req_ready = (state == IDLE) && !flush_pending && !bus.flush;
   assign accept    = bus.core_req_valid && bus.core_req_ready;
   assign hit       = valid_bits[req_idx] && (tag_ram[req_idx] == req_tag);
   assign beat      = (state == REFILL) && bus.mem_rsp_valid;
   assign last_beat = (beat_cnt == OFF'(LINE_WORDS - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next         = state;
      bus.core_rsp_valid = 1'b0;
      bus.core_rsp_data  = '0;
      bus.mem_req_valid  = 1'b0;
      bus.mem_req_addr   = '0;
      sram_csb0          = 1'b1;
      sram_web0          = 1'b1;
      sram_wmask0        = 4'h0;
      sram_addr0         = '0;
      sram_din0          = '0;
      sram_csb1          = 1'b1;
      sram_addr1         = '0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               sram_csb1  = 1'b0;
               sram_addr1 = {in_idx, in_off};
               state_next = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               bus.core_rsp_valid = 1'b1;
               bus.core_rsp_data  = sram_dout1;
               state_next         = IDLE;
            end else begin
               state_next = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_addr  = {req_tag, req_idx, {(OFF + 2){1'b0}}};
            if (bus.mem_req_ready) begin
               state_next = REFILL;
            end
         end
         REFILL: begin
            if (bus.mem_rsp_valid) begin
               sram_csb0   = 1'b0;
               sram_web0   = 1'b0;
               sram_wmask0 = 4'hF;
               sram_addr0  = {req_idx, beat_cnt};
               sram_din0   = bus.mem_rsp_data;
               if (last_beat) begin
                  state_next = RESPOND;
               end
            end
         end
         RESPOND: begin
            bus.core_rsp_valid = 1'b1;
            bus.core_rsp_data  = crit_word;
            state_next         = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request latch, refill beat tracking, tag/valid update and flush handling.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_tag       <= '0;
         req_idx       <= '0;
         req_off       <= '0;
         beat_cnt      <= '0;
         crit_word     <= '0;
         flush_pending <= 1'b0;
         valid_bits    <= '0;
         for (int i = 0; i < LINES; i++) begin
            tag_ram[i] <= '0;
         end
      end else begin
         if (accept) begin
            req_tag <= in_tag;
            req_idx <= in_idx;
            req_off <= in_off;
         end
         if ((state == REFILL_REQ) && bus.mem_req_ready) begin
            beat_cnt <= '0;
         end
         if (beat) begin
            if (beat_cnt == req_off) begin
               crit_word <= bus.mem_rsp_data;
            end
            beat_cnt <= beat_cnt + OFF'(1);
            if (last_beat) begin
               valid_bits[req_idx] <= 1'b1;
               tag_ram[req_idx]    <= req_tag;
            end
         end
         // The in-flight miss still installs its line; the clear waits for IDLE.
         if ((state == IDLE) && (bus.flush || flush_pending)) begin
            valid_bits    <= '0;
            flush_pending <= 1'b0;
         end else if ((state != IDLE) && bus.flush) begin
            flush_pending <= 1'b1;
         end
      end
   end

endmodule
